fifo32_rd_ctrl: RTL

Read-side controller for the 32-entry circular buffer built from `ramd32x1` slices (one slice per data bit). It consumes the write pointer published by the buffer's write controller and drives the RAM read address. It registers RAM read data into a valid/ready output stage and returns its own read pointer to the writer for full detection. It sits between the bit-sliced dual-port RAM and any downstream consumer in the same clock domain.

---
 rtl/fifo32_pkg.sv | 16 +
 rtl/fifo32_rd_ctrl_if.sv | 31 +++
 rtl/fifo32_level.sv | 33 +++
 rtl/fifo32_rd_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/fifo32_pkg.sv
// Shared constants, pointer type and pointer arithmetic for the 32-entry
// bit-sliced circular buffer; used by both the read and write controllers.
package fifo32_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int PTR_W  = 6;

  // Bit 5 is the wrap bit; it tells full from empty when the address bits match.
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/fifo32_rd_ctrl_if.sv
// Read-side bundle: writer pointer, RAM read port, output stage and status.
// The slave modport belongs to fifo32_rd_ctrl; master is the surrounding system.
interface fifo32_rd_ctrl_if #(
  parameter int WIDTH = 8
);
  import fifo32_pkg::*;

  ptr_t               wr_ptr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [WIDTH-1:0]   ram_rdata;
  ptr_t               rd_ptr;
  logic [WIDTH-1:0]   dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               flush;
  logic               empty;
  logic               aempty;
  logic [PTR_W-1:0]   level;
  logic               err;

  modport master (
    output wr_ptr, ram_rdata, dout_ready, flush,
    input  rd_addr, rd_ptr, dout, dout_valid, empty, aempty, level, err
  );

  modport slave (
    input  wr_ptr, ram_rdata, dout_ready, flush,
    output rd_addr, rd_ptr, dout, dout_valid, empty, aempty, level, err
  );

endinterface

// File: rtl/fifo32_level.sv
// Occupancy arithmetic from the two pointers: level, empty, almost-empty and
// the overrun compare (built only when FIFO32_RD_ERRCHK_EN is defined).
module fifo32_level
  import fifo32_pkg::*;
#(
  parameter int AEMPTY_TH = 4
) (
  input  ptr_t             wr_ptr_i,
  input  ptr_t             rd_ptr_i,
  input  logic             out_valid_i,
  output logic             buf_empty_o,
  output logic [PTR_W-1:0] level_o,
  output logic             empty_o,
  output logic             aempty_o,
  output logic             overrun_o
);

  ptr_t diff;

  assign diff        = ptr_diff(wr_ptr_i, rd_ptr_i);
  assign buf_empty_o = (wr_ptr_i == rd_ptr_i);
  // The output stage counts as one held word, so level reaches 33 when full.
  assign level_o     = diff + PTR_W'(out_valid_i);
  assign empty_o     = buf_empty_o && !out_valid_i;
  assign aempty_o    = (int'(level_o) <= AEMPTY_TH);

`ifdef FIFO32_RD_ERRCHK_EN
  assign overrun_o   = (diff > PTR_W'(DEPTH));
`else
  assign overrun_o   = 1'b0;
`endif

endmodule

// File: rtl/fifo32_rd_ctrl.sv
// Read controller for the 32-entry ramd32x1 buffer: stages RAM data into a
// valid/ready register. Define FIFO32_RD_ERRCHK_EN to build the sticky err flag.
module fifo32_rd_ctrl
  import fifo32_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int AEMPTY_TH = 4
) (
  input logic              clk,
  input logic              mr,
  fifo32_rd_ctrl_if.slave  bus
);

  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             buf_empty;
  logic             load;
  logic             overrun;

  fifo32_level #(
    .AEMPTY_TH (AEMPTY_TH)
  ) u_level (
    .wr_ptr_i    (bus.wr_ptr),
    .rd_ptr_i    (rd_ptr_q),
    .out_valid_i (dout_valid_q),
    .buf_empty_o (buf_empty),
    .level_o     (bus.level),
    .empty_o     (bus.empty),
    .aempty_o    (bus.aempty),
    .overrun_o   (overrun)
  );

  // Refill whenever the stage is free or is being emptied this cycle.
  assign load = !buf_empty && (!dout_valid_q || bus.dout_ready);

  always_comb begin
    // NOTE: every next-state value gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    rd_ptr_d     = rd_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (bus.flush) begin
      rd_ptr_d     = bus.wr_ptr;
      dout_valid_d = 1'b0;
    end else if (load) begin
      dout_d       = bus.ram_rdata;
      dout_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef FIFO32_RD_ERRCHK_EN
  logic err_q;

  // Sticky: only mr clears it; flush deliberately leaves it set.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      err_q <= 1'b0;
    end else if (overrun) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  wire unused_overrun = overrun;

  assign bus.err = 1'b0;
`endif

  assign bus.rd_ptr     = rd_ptr_q;
  assign bus.rd_addr    = rd_ptr_q[ADDR_W-1:0];
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
